// File: rtl/tri_cmd_sequencer.sv
// Host word-stream parser feeding triangles to the rasteriser with a credit limit.
// Optional protocol error pulse enabled by defining TRI_CMD_ERR_CHECK_EN.
module tri_cmd_sequencer #(
    parameter logic [31:0] FRAME_START_WORD = 32'd0,
    parameter logic [31:0] FRAME_END_WORD   = 32'd1,
    parameter int          MAX_OUTSTANDING  = 4,
    parameter int          CNT_W            = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [31:0]      ahb_buffer,
    input  logic             ahb_data_available,
    output logic             ahb_user_read_buffer,
    output logic [143:0]     triangle,
    output logic [23:0]      color,
    output logic             tri_ready,
    input  logic             tri_read,
    input  logic             cf_done,
    output logic             frame_busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] tri_count,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PRESENT,
        DRAIN
    } state_t;

    localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] outstanding;

    logic accept;
    logic handshake;
    logic cf_take;
    logic cnt_sat;
    logic credit_ok;

    always_comb begin
        credit_ok = (idx != 3'd0) || (outstanding < MAX_O);
        accept    = ahb_data_available && !ahb_user_read_buffer &&
                    ((state == IDLE) ||
                     ((state == COLLECT) && credit_ok));
        handshake = (state == PRESENT) && tri_ready && tri_read;
        cf_take   = cf_done && (outstanding != 4'd0);
        cnt_sat   = &tri_count;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                <= IDLE;
            idx                  <= 3'd0;
            outstanding          <= 4'd0;
            ahb_user_read_buffer <= 1'b0;
            triangle             <= '0;
            color                <= '0;
            tri_ready            <= 1'b0;
            frame_busy           <= 1'b0;
            frame_done           <= 1'b0;
            tri_count            <= '0;
        end else begin
            ahb_user_read_buffer <= accept;
            frame_done           <= 1'b0;
            outstanding          <= outstanding + 4'(handshake)
                                                - 4'(cf_take);
            unique case (state)
                IDLE: begin
                    if (accept && ahb_buffer == FRAME_START_WORD) begin
                        state      <= COLLECT;
                        idx        <= 3'd0;
                        frame_busy <= 1'b1;
                        tri_count  <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (idx == 3'd0 && ahb_buffer == FRAME_END_WORD) begin
                            state <= DRAIN;
                        end else begin
                            unique case (idx)
                                3'd0: begin
                                    triangle[143:128] <= ahb_buffer[15:0];
                                    triangle[127:112] <= ahb_buffer[31:16];
                                end
                                3'd1: begin
                                    triangle[111:96] <= ahb_buffer[15:0];
                                    triangle[95:80]  <= ahb_buffer[31:16];
                                end
                                3'd2: begin
                                    triangle[79:64] <= ahb_buffer[15:0];
                                    triangle[63:48] <= ahb_buffer[31:16];
                                end
                                3'd3: begin
                                    triangle[47:32] <= ahb_buffer[15:0];
                                    triangle[31:16] <= ahb_buffer[31:16];
                                end
                                3'd4: begin
                                    triangle[15:0] <= ahb_buffer[15:0];
                                    color[23:16]   <= ahb_buffer[23:16];
                                    color[15:8]    <= ahb_buffer[31:24];
                                end
                                3'd5: begin
                                    color[7:0] <= ahb_buffer[7:0];
                                end
                                default: begin
                                end
                            endcase
                            if (idx == 3'd5) begin
                                idx       <= 3'd0;
                                tri_ready <= 1'b1;
                                state     <= PRESENT;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        tri_ready <= 1'b0;
                        idx       <= 3'd0;
                        state     <= COLLECT;
                        if (!cnt_sat)
                            tri_count <= tri_count + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (outstanding == 4'd0) begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRI_CMD_ERR_CHECK_EN
    logic drop_err;
    logic cf_err;
    logic sat_err;

    always_comb begin
        drop_err = accept && (state == IDLE) &&
                   (ahb_buffer != FRAME_START_WORD);
        cf_err   = cf_done && (outstanding == 4'd0);
        sat_err  = handshake && cnt_sat;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            proto_err <= 1'b0;
        else
            proto_err <= drop_err || cf_err || sat_err;
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_tri_cmd_sequencer.sv
// Directed scoreboard bench for tri_cmd_sequencer.
// Host words go through a queue; expected triangles are popped on handshake.
module tb_tri_cmd_sequencer;

    logic         tb_clk = 1'b0;
    logic         n_rst;
    logic [31:0]  ahb_buffer;
    logic         ahb_data_available;
    logic         ahb_user_read_buffer;
    logic [143:0] triangle;
    logic [23:0]  color;
    logic         tri_ready;
    logic         tri_read;
    logic         cf_done;
    logic         frame_busy;
    logic         frame_done;
    logic [15:0]  tri_count;
    logic         proto_err;

    always #5 tb_clk = ~tb_clk;

    tri_cmd_sequencer dut (
        .clk                  (tb_clk),
        .n_rst                (n_rst),
        .ahb_buffer           (ahb_buffer),
        .ahb_data_available   (ahb_data_available),
        .ahb_user_read_buffer (ahb_user_read_buffer),
        .triangle             (triangle),
        .color                (color),
        .tri_ready            (tri_ready),
        .tri_read             (tri_read),
        .cf_done              (cf_done),
        .frame_busy           (frame_busy),
        .frame_done           (frame_done),
        .tri_count            (tri_count),
        .proto_err            (proto_err)
    );

    int checks = 0;
    int errors = 0;
    int reads  = 0;
    int dones  = 0;
    int hs_cnt = 0;
    bit err_seen = 1'b0;

    logic [31:0]  wq[$];
    logic [167:0] sb[$];

    task automatic chk(input string tag, input logic [199:0] obs,
                       input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic         hs;
        logic [167:0] e;
        ahb_data_available = (wq.size() != 0);
        ahb_buffer = (wq.size() != 0) ? wq[0] : 32'h0;
        hs = tri_ready & tri_read;
        if (hs) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                chki("sb_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("tri_color", 200'({triangle, color}), 200'(e));
            end
        end
        @(posedge tb_clk);
        #1;
        if (ahb_user_read_buffer) begin
            reads++;
            if (wq.size() != 0) void'(wq.pop_front());
        end
        if (frame_done) dones++;
        if (proto_err) err_seen = 1'b1;
        cf_done = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!tri_ready && n < 100) begin
            tick();
            n++;
        end
        chkb(tag, tri_ready, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!frame_done && n < 100) begin
            tick();
            n++;
        end
        chkb(tag, frame_done, 1'b1);
    endtask

    // Word packing derived independently from the host format.
    task automatic push_tri(input logic [143:0] t, input logic [23:0] c,
                            input int nw);
        logic [31:0] w[6];
        logic [31:0] rw;
        rw = $urandom();
        w[0] = {t[127:112], t[143:128]};
        w[1] = {t[95:80], t[111:96]};
        w[2] = {t[63:48], t[79:64]};
        w[3] = {t[31:16], t[47:32]};
        w[4] = {c[15:8], c[23:16], t[15:0]};
        w[5] = {rw[31:8], c[7:0]};
        for (int i = 0; i < nw; i++) wq.push_back(w[i]);
        if (nw == 6) sb.push_back({t, c});
    endtask

    function automatic logic [143:0] rand_tri();
        logic [143:0] t;
        for (int j = 0; j < 9; j++) t[j*16 +: 16] = 16'($urandom() | 32'h100);
        return t;
    endfunction

    logic [143:0] t1, ta, tb_t, tc, t;
    logic [23:0]  c1, ca, col;
    int r0, r1, h0, d0, n;

    initial begin
        n_rst = 1'b0;
        ahb_buffer = 32'h0;
        ahb_data_available = 1'b0;
        tri_read = 1'b0;
        cf_done = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1;
        chk("reset_outputs", 200'({ahb_user_read_buffer, triangle, color,
            tri_ready, frame_busy, frame_done, tri_count, proto_err}), '0);
        n_rst = 1'b1;

        t1 = {16'd320, 16'd430, 16'd50, 16'd80, 16'd479, 16'd30,
              16'd560, 16'd479, 16'd30};
        c1 = {8'd255, 8'd0, 8'd0};
        wq.push_back(32'd0);
        push_tri(t1, c1, 6);
        wq.push_back(32'd1);
        wait_ready("t1_ready");
        chki("t1_reads", reads, 7);
        chk("t1_tri", 200'({triangle, color}), 200'({t1, c1}));
        chkb("t1_busy", frame_busy, 1'b1);
        tri_read = 1'b1;
        tick();
        tri_read = 1'b0;
        chki("t1_hs", hs_cnt, 1);
        chki("t1_count", int'(tri_count), 1);
        chkb("t1_ready_drop", tri_ready, 1'b0);
        repeat (5) tick();
        chki("t1_end_read", reads, 8);
        chki("t1_no_early_done", dones, 0);
        cf_done = 1'b1;
        tick();
        wait_done("t1_done");
        chkb("t1_busy_fall", frame_busy, 1'b0);
        repeat (3) tick();
        chki("t1_done_once", dones, 1);

        r0 = reads; h0 = hs_cnt; d0 = dones;
        tri_read = 1'b1;
        wq.push_back(32'd0);
        for (int i = 0; i < 8; i++) begin
            t = rand_tri();
            col = 24'($urandom());
            if (i == 1) t[143:112] = 32'h0;
            if (i == 2) t[111:80] = 32'h0001_0000 >> 16;
            push_tri(t, col, 6);
        end
        wq.push_back(32'd1);
        repeat (150) tick();
        chki("t2_stall_hs", hs_cnt - h0, 4);
        chki("t2_stall_reads", reads - r0, 25);
        chki("t2_stall_count", int'(tri_count), 4);
        for (int k = 0; k < 4; k++) begin
            cf_done = 1'b1;
            tick();
            repeat (40) tick();
            chki($sformatf("t2_release%0d", k), hs_cnt - h0, 5 + k);
        end
        chki("t2_count", int'(tri_count), 8);
        chki("t2_end_blocked", dones - d0, 0);
        repeat (3) begin
            cf_done = 1'b1;
            tick();
            tick();
        end
        cf_done = 1'b1;
        tick();
        wait_done("t2_done");
        tri_read = 1'b0;
        tick();

        r0 = reads; h0 = hs_cnt; d0 = dones;
        ta = rand_tri(); ca = 24'($urandom());
        tb_t = rand_tri(); tc = rand_tri();
        wq.push_back(32'd0);
        push_tri(ta, ca, 6);
        push_tri(tb_t, 24'h123456, 6);
        push_tri(tc, 24'habcdef, 6);
        wq.push_back(32'd1);
        wait_ready("t3_ready");
        r1 = reads;
        repeat (20) tick();
        chkb("t3_hold_ready", tri_ready, 1'b1);
        chki("t3_no_reads", reads, r1);
        chk("t3_stable", 200'({triangle, color}), 200'({ta, ca}));
        chki("t3_no_hs", hs_cnt - h0, 0);
        tri_read = 1'b1;
        tick();
        tri_read = 1'b0;
        wait_ready("t3_b_ready");
        chki("t3_one_hs", hs_cnt - h0, 1);
        tri_read = 1'b1;
        tick();
        tri_read = 1'b0;
        wait_ready("t4_c_ready");
        tri_read = 1'b1;
        cf_done = 1'b1;
        tick();
        tri_read = 1'b0;
        repeat (10) tick();
        chkb("t4_busy", frame_busy, 1'b1);
        chki("t4_no_done", dones - d0, 0);
        cf_done = 1'b1;
        tick();
        repeat (10) tick();
        chki("t4_one_cf_left", dones - d0, 0);
        cf_done = 1'b1;
        tick();
        wait_done("t4_done");
        chki("t4_hs", hs_cnt - h0, 3);
        chki("t4_count", int'(tri_count), 3);

        chkb("no_spurious_err", err_seen, 1'b0);
        r0 = reads;
        wq.push_back(32'h5);
        repeat (4) tick();
        chki("t5_consumed", reads - r0, 1);
        chkb("t5_idle_busy", frame_busy, 1'b0);
        chkb("t5_idle_ready", tri_ready, 1'b0);
`ifdef TRI_CMD_ERR_CHECK_EN
        chkb("t5_proto_err", err_seen, 1'b1);
`else
        chkb("t5_proto_err", err_seen, 1'b0);
`endif

        r0 = reads;
        wq.push_back(32'd0);
        push_tri(rand_tri(), 24'h777777, 4);
        n = 0;
        while (reads - r0 < 5 && n < 100) begin
            tick();
            n++;
        end
        chki("t6_partial_reads", reads - r0, 5);
        chkb("t6_busy_before", frame_busy, 1'b1);
        #1 n_rst = 1'b0;
        #1;
        chk("t6_reset_outputs", 200'({ahb_user_read_buffer, triangle, color,
            tri_ready, frame_busy, frame_done, tri_count, proto_err}), '0);
        wq.delete();
        ahb_data_available = 1'b0;
        @(posedge tb_clk);
        #1 n_rst = 1'b1;
        h0 = hs_cnt; d0 = dones;
        wq.push_back(32'd0);
        push_tri(rand_tri(), 24'h00ff80, 6);
        wq.push_back(32'd1);
        tri_read = 1'b1;
        wait_ready("t6_ready");
        tick();
        tri_read = 1'b0;
        chki("t6_hs", hs_cnt - h0, 1);
        chki("t6_count", int'(tri_count), 1);
        repeat (5) tick();
        cf_done = 1'b1;
        tick();
        wait_done("t6_done");
        chki("t6_done_once", dones - d0, 1);
        chki("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_cmd_sequencer.md
Name: tri_cmd_sequencer

Overview:
Front-end controller between the AHB slave word buffer and the GPU raster pipeline. It parses the host word stream: a frame-start word, then six words per triangle, then a frame-end word. It assembles each Triangle3D and Color, presents them to the rasteriser with a ready/read handshake, and limits outstanding triangles using the cf_done completions. It signals frame completion once every issued triangle has been drawn.

Parameters:
FRAME_START_WORD, 32'd0, header word that opens a frame
FRAME_END_WORD, 32'd1, header word that closes a frame (recognised only at word index 0 inside a frame)
MAX_OUTSTANDING, 4, maximum number of triangles issued but not yet drawn (range 1..15)
CNT_W, 16, width of the per-frame triangle counter

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
ahb_buffer  in  32  current host word
ahb_data_available  in  1  ahb_buffer holds a valid unconsumed word
ahb_user_read_buffer  out  1  one-cycle pulse: word consumed
triangle  out  144  Triangle3D {p,q,r}{x,y,z}, 16 b per coordinate
color  out  24  Color {r,g,b}, 8 b each
tri_ready  out  1  triangle/color valid for rasteriser
tri_read  in  1  rasteriser takes triangle (handshake when tri_ready & tri_read)
cf_done  in  1  one-cycle pulse per triangle fully drawn
frame_busy  out  1  high from frame-start accept until frame_done
frame_done  out  1  one-cycle pulse: frame ended and all triangles drawn
tri_count  out  CNT_W  triangles issued this frame (saturating)
proto_err  out  1  see Optional Feature

Behaviour:
- Reset (async, n_rst=0): state IDLE. All outputs 0. Word index, outstanding count, tri_count, triangle and color are cleared. An in-flight triangle is discarded.
- Word accept: a word is accepted in a cycle where ahb_data_available=1, ahb_user_read_buffer=0, and the state is IDLE or COLLECT (in COLLECT at index 0, acceptance also requires outstanding < MAX_OUTSTANDING). ahb_user_read_buffer pulses high the next cycle. No word is ever accepted two cycles running.
- IDLE: word==FRAME_START_WORD -> COLLECT, idx=0, frame_busy=1, tri_count=0. Any other word is consumed and dropped.
- COLLECT: the word at idx 0 equal to FRAME_END_WORD -> DRAIN. Otherwise words are stored by idx:
  - w0 = p.x[15:0], p.y[31:16]
  - w1 = p.z, q.x
  - w2 = q.y, q.z
  - w3 = r.x, r.y
  - w4 = r.z[15:0], col.r[23:16], col.g[31:24]
  - w5 = col.b[7:0], bits [31:8] ignored
  - idx increments. When w5 is accepted in cycle N, tri_ready=1 in cycle N+1 and the state goes to PRESENT.
- PRESENT: triangle and color are held stable. On tri_ready & tri_read: tri_ready drops next cycle, outstanding+1, tri_count+1, idx=0, back to COLLECT. No words are accepted in PRESENT.
- DRAIN: no words accepted. When outstanding==0, frame_done pulses, frame_busy=0, and the state goes to IDLE in the same cycle.
- Outstanding counter: +1 on handshake, -1 on cf_done. Both in the same cycle leaves it unchanged. cf_done with outstanding==0 is ignored (no underflow).
- The frame-start header is only meaningful in IDLE. FRAME_START_WORD inside a frame is treated as coordinate data.

Optional Feature:
TRI_CMD_ERR_CHECK_EN. When defined, proto_err pulses one cycle on any of:
- a non-start word dropped in IDLE
- cf_done while outstanding==0
- tri_count saturation
When undefined, proto_err is tied to 0, the same events are handled silently as above, and no checker logic is generated.

Test Plan:
- Reset, then frame start, one triangle p=(320,430,50) q=(80,479,30) r=(560,479,30), col=(255,0,0), frame end, one cf_done -> six read pulses after the header, then tri_ready with triangle/color matching bit-exactly. After the handshake tri_count=1, then frame_done pulses exactly once, and frame_busy falls in the same cycle.
- 8 triangles with tri_read tied 1 and cf_done withheld, MAX_OUTSTANDING=4 -> 4 triangles issue, then the read pulses stop at idx 0 of triangle 5. Each later cf_done releases exactly one triangle. tri_count reaches 8.
- tri_read held 0 for 20 cycles while ahb_data_available=1 -> tri_ready stays high, outputs stay stable, no read pulses. On release, exactly one handshake occurs.
- tri_read handshake and cf_done in the same cycle, with outstanding=2 -> outstanding stays 2. Frame end followed by two more cf_done pulses gives frame_done.
- Word 32'h5 in IDLE -> consumed, state stays IDLE, frame_busy=0; proto_err=1 only with TRI_CMD_ERR_CHECK_EN.
- n_rst asserted after w3 of a triangle -> all outputs 0 immediately. A subsequent fresh frame works correctly with no residue from the partial triangle.
